sar_conv_sequencer: RTL

Conversion sequencer for the 10-bit charge-sharing SAR core. It issues single or periodic conversion starts and watches end-of-conversion. It optionally averages bursts of 2^N conversions and holds each result in a ready/valid output register for the digital back end. It sits between the SAR core (drives `cnvst`, samples `sar`/`eoc`) and the system bus/DSP.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_conv_sequencer_avg.sv | 46 ++++
 rtl/sar_conv_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
// Optional averaging is enabled with the SAR_SEQ_AVG_EN macro.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_EOC = 2'd2,
        DONE     = 2'd3
    } sar_state_e;

    localparam int SAR_DATA_W       = 10;
    localparam int SAR_MAX_AVG_LOG2 = 3;

endpackage

// File: rtl/sar_conv_sequencer_avg.sv
// Burst averager: accumulates 2^log2 samples and shifts the sum down.
// Instantiated by sar_conv_sequencer only when SAR_SEQ_AVG_EN is defined.
module sar_seq_avg
    import sar_pkg::*;
#(
    parameter int DATA_W       = SAR_DATA_W,
    parameter int MAX_AVG_LOG2 = SAR_MAX_AVG_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [2:0]        log2_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              last_o,
    output logic [DATA_W-1:0] result_o
);
    localparam int ACC_W = DATA_W + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       log2_q;
    logic [ACC_W-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            log2_q <= '0;
        end else if (clr_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            log2_q <= log2_i;
        end else if (add_i) begin
            acc_q <= acc_q + ACC_W'(data_i);
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The sample being added now completes the burst.
    assign last_o   = (cnt_q + CNT_W'(1)) == (CNT_W'(1) << log2_q);
    assign shifted  = acc_q >> log2_q;
    assign result_o = shifted[DATA_W-1:0];

endmodule

// File: rtl/sar_conv_sequencer.sv
// Conversion sequencer for the SAR core: launches, timeouts, result register.
// Define SAR_SEQ_AVG_EN to average bursts of 2^avg_log2 conversions.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter int DATA_W       = SAR_DATA_W,
    parameter int PERIOD_W     = 16,
    parameter int MAX_AVG_LOG2 = SAR_MAX_AVG_LOG2,
    parameter int TIMEOUT      = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [2:0]          avg_log2,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_eoc,
    output logic                cnvst,
    output logic                busy,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                clr_err
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    sar_state_e          state_q;
    logic [PERIOD_W-1:0] timer_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                cnvst_q;
    logic                busy_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_valid_q;
    logic                overrun_q;
    logic                timeout_q;

    logic [PERIOD_W:0]   timer_nx;
    logic                launch;
    logic                eoc_hit;
    logic                wait_expired;
    logic                ov_set;
    logic                last_smp;
    logic [DATA_W-1:0]   result;

    assign timer_nx     = {1'b0, timer_q} + {{PERIOD_W{1'b0}}, 1'b1};
    assign launch       = (state_q == IDLE) &&
                          (trig || (en && (timer_nx >= {1'b0, period})));
    assign eoc_hit      = (state_q == WAIT_EOC) && adc_eoc;
    assign wait_expired = (state_q == WAIT_EOC) && !adc_eoc &&
                          (wcnt_q == WCNT_W'(TIMEOUT - 1));
    assign ov_set       = (state_q == DONE) && res_valid_q && !res_ready;

`ifdef SAR_SEQ_AVG_EN
    logic [2:0] log2_c;

    assign log2_c = (avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : avg_log2;

    sar_seq_avg #(
        .DATA_W       (DATA_W),
        .MAX_AVG_LOG2 (MAX_AVG_LOG2)
    ) u_avg (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (launch),
        .log2_i   (log2_c),
        .add_i    (eoc_hit),
        .data_i   (adc_data),
        .last_o   (last_smp),
        .result_o (result)
    );
`else
    logic [DATA_W-1:0] hold_q;
    logic              unused_avg;

    // Hold the sample for one cycle so result latency matches the averaging build.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (eoc_hit) begin
            hold_q <= adc_data;
        end
    end

    assign last_smp   = 1'b1;
    assign result     = hold_q;
    assign unused_avg = ^{avg_log2, MAX_AVG_LOG2[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            wcnt_q      <= '0;
            cnvst_q     <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timer_q   <= launch    ? '0      :
                         (&timer_q) ? timer_q : timer_q + 1'b1;
            timeout_q <= wait_expired | (timeout_q & ~clr_err);
            overrun_q <= ov_set | (overrun_q & ~clr_err);
            cnvst_q   <= 1'b0;
            if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= START;
                        cnvst_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                // Back-to-back entries spend one settle cycle here before the pulse.
                START: begin
                    if (cnvst_q) begin
                        state_q <= WAIT_EOC;
                        wcnt_q  <= '0;
                    end else begin
                        cnvst_q <= 1'b1;
                    end
                end
                WAIT_EOC: begin
                    if (adc_eoc) begin
                        state_q <= last_smp ? DONE : START;
                    end else if (wait_expired) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                DONE: begin
                    res_data_q  <= result;
                    res_valid_q <= 1'b1;
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cnvst       = cnvst_q;
    assign busy        = busy_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule
